// File: rtl/bch_bm_ctrl.sv
// Step sequencer for the iterative binary BCH Berlekamp-Massey datapath: owns L, picks the update mode.
// Optional BCH_BM_CTRL_ZERO_BYPASS_EN: an all-zero syndrome set skips every step and reports L=0.
module bch_bm_ctrl #(
  parameter  int unsigned t  = 8,
  localparam int unsigned t2 = 2 * t,
  localparam int unsigned RW = $clog2(t2 + 1)
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic          isyndrome_val,
  input  logic          isyndrome_zero,
  output logic          osyndrome_rdy,
  output logic          odp_load,
  output logic          odp_delta_start,
  input  logic          idp_delta_val,
  input  logic          idp_delta_zero,
  output logic          odp_upd_start,
  output logic [1:0]    odp_upd_mode,
  output logic          odp_first,
  output logic [RW-1:0] odp_r,
  input  logic          idp_upd_done,
  input  logic [RW-1:0] idp_deg,
  input  logic          iout_busy,
  output logic          oloc_poly_val,
  output logic [RW-1:0] oloc_L,
  output logic          oloc_failed,
  output logic          ooverflow
);

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_UPDATE = 2'd1;
  localparam logic [1:0] MODE_SWAP   = 2'd2;

  typedef enum logic [2:0] {IDLE, LOAD, DELTA, WAIT_D, UPD, WAIT_U, CHECK, OUT} state_t;

  state_t        state, state_n;
  logic [RW-1:0] r, r_n;
  logic [RW-1:0] l_reg, l_n;
  logic [1:0]    mode, mode_n;
  logic          fail_q, fail_n;
  logic          poly_n;
  logic [RW-1:0] loc_l_n;
  logic          loc_f_n;
  logic [RW:0]   two_l;
  logic [RW:0]   r_m1;

`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
  logic zero_q, zero_n;
`else
  logic unused_zero;
  assign unused_zero = isyndrome_zero;
`endif

  // SWAP test 2L <= r-1, evaluated one bit wider than L so 2L cannot wrap
  assign two_l = {l_reg, 1'b0};
  assign r_m1  = {1'b0, r} - (RW+1)'(1);

  assign odp_r        = r;
  assign odp_upd_mode = mode;

  // Next-state, register and output decode
  always_comb begin
    state_n = state;
    r_n     = r;
    l_n     = l_reg;
    mode_n  = mode;
    fail_n  = fail_q;
    poly_n  = 1'b0;
    loc_l_n = oloc_L;
    loc_f_n = oloc_failed;
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
    zero_n  = zero_q;
`endif
    case (state)
      IDLE: begin
        if (isyndrome_val) begin
          state_n = LOAD;
          l_n     = '0;
          r_n     = RW'(1);
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
          zero_n  = isyndrome_zero;
`endif
        end
      end
      LOAD: begin
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
        state_n = zero_q ? CHECK : DELTA;
`else
        state_n = DELTA;
`endif
      end
      DELTA: state_n = WAIT_D;
      WAIT_D: begin
        if (idp_delta_val) begin
          state_n = UPD;
          if (idp_delta_zero) begin
            mode_n = MODE_SHIFT;
          end else if (two_l <= r_m1) begin
            mode_n = MODE_SWAP;
            l_n    = r - l_reg;
          end else begin
            mode_n = MODE_UPDATE;
          end
        end
      end
      UPD: state_n = WAIT_U;
      WAIT_U: begin
        if (idp_upd_done) begin
          if (r == RW'(t2 - 1)) begin
            state_n = CHECK;
          end else begin
            state_n = DELTA;
            r_n     = r + RW'(2);
          end
        end
      end
      CHECK: begin
        state_n = OUT;
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
        if (zero_q) begin
          fail_n = 1'b0;
          l_n    = '0;
        end else begin
          fail_n = (idp_deg != l_reg);
        end
`else
        fail_n = (idp_deg != l_reg);
`endif
      end
      OUT: begin
        if (!iout_busy) begin
          state_n = IDLE;
          poly_n  = 1'b1;
          loc_l_n = l_reg;
          loc_f_n = fail_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state           <= IDLE;
      r               <= '0;
      l_reg           <= '0;
      mode            <= MODE_SHIFT;
      fail_q          <= 1'b0;
      osyndrome_rdy   <= 1'b1;
      odp_load        <= 1'b0;
      odp_delta_start <= 1'b0;
      odp_upd_start   <= 1'b0;
      odp_first       <= 1'b0;
      oloc_poly_val   <= 1'b0;
      oloc_L          <= '0;
      oloc_failed     <= 1'b0;
      ooverflow       <= 1'b0;
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
      zero_q          <= 1'b0;
`endif
    end else begin
      state           <= state_n;
      r               <= r_n;
      l_reg           <= l_n;
      mode            <= mode_n;
      fail_q          <= fail_n;
      osyndrome_rdy   <= (state_n == IDLE);
      odp_load        <= (state_n == LOAD);
      odp_delta_start <= (state_n == DELTA);
      odp_upd_start   <= (state_n == UPD);
      odp_first       <= (r_n == RW'(1));
      oloc_poly_val   <= poly_n;
      oloc_L          <= loc_l_n;
      oloc_failed     <= loc_f_n;
      ooverflow       <= ooverflow | (isyndrome_val & (state != IDLE));
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
      zero_q          <= zero_n;
`endif
    end
  end

endmodule

// File: tb/tb_bch_bm_ctrl.sv
// Directed bench for bch_bm_ctrl (t=8): mode/L traces, latency, stalls, overflow, reset, zero syndromes.
module tb_bch_bm_ctrl;

  localparam int unsigned RW = 5;

  logic          iclk = 1'b0;
  logic          ireset;
  logic          isyndrome_val, isyndrome_zero;
  logic          osyndrome_rdy, odp_load, odp_delta_start;
  logic          idp_delta_val, idp_delta_zero;
  logic          odp_upd_start;
  logic [1:0]    odp_upd_mode;
  logic          odp_first;
  logic [RW-1:0] odp_r;
  logic          idp_upd_done;
  logic [RW-1:0] idp_deg;
  logic          iout_busy;
  logic          oloc_poly_val;
  logic [RW-1:0] oloc_L;
  logic          oloc_failed, ooverflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_delta = 0;
  int n_upd = 0;
  int n_poly = 0;

  bch_bm_ctrl dut (
    .iclk(iclk), .ireset(ireset),
    .isyndrome_val(isyndrome_val), .isyndrome_zero(isyndrome_zero),
    .osyndrome_rdy(osyndrome_rdy), .odp_load(odp_load),
    .odp_delta_start(odp_delta_start),
    .idp_delta_val(idp_delta_val), .idp_delta_zero(idp_delta_zero),
    .odp_upd_start(odp_upd_start), .odp_upd_mode(odp_upd_mode),
    .odp_first(odp_first), .odp_r(odp_r),
    .idp_upd_done(idp_upd_done), .idp_deg(idp_deg),
    .iout_busy(iout_busy),
    .oloc_poly_val(oloc_poly_val), .oloc_L(oloc_L),
    .oloc_failed(oloc_failed), .ooverflow(ooverflow)
  );

  always #5 iclk = ~iclk;

  // Cycle count and strobe counters
  always @(posedge iclk) begin
    cyc <= cyc + 1;
    if (odp_delta_start) n_delta <= n_delta + 1;
    if (odp_upd_start)   n_upd   <= n_upd + 1;
    if (oloc_poly_val)   n_poly  <= n_poly + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One syndrome set: nz bit k = nonzero delta at step k; modes packed 2 bits per step
  task automatic do_run(input logic [7:0] nz, input logic [15:0] modes, input logic [RW-1:0] exp_l,
                        input logic [RW-1:0] deg, input logic exp_fail, input int dly, input int busy_n,
                        input int ovf_step, input int exp_lat, input logic zero, input logic bypass);
    int c0, n, d0, u0, p0;
    d0 = n_delta; u0 = n_upd; p0 = n_poly;
    @(negedge iclk);
    chk("rdy_idle", 32'(osyndrome_rdy), 32'd1);
    isyndrome_val = 1'b1; isyndrome_zero = zero; iout_busy = (busy_n > 0); idp_deg = deg;
    @(negedge iclk);
    c0 = cyc;
    isyndrome_val = 1'b0; isyndrome_zero = 1'b0;
    chk("rdy_drop", 32'(osyndrome_rdy), 32'd0);
    chk("load", 32'(odp_load), 32'd1);
    if (bypass) begin
      @(negedge iclk);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n = 0;
        while (!odp_delta_start && n < 20) begin @(negedge iclk); n++; end
        chk("delta_start", 32'(odp_delta_start), 32'd1);
        chk("step_r", 32'(odp_r), 32'(2 * k + 1));
        chk("first", 32'(odp_first), 32'(k == 0));
        if (k == ovf_step) isyndrome_val = 1'b1;
        repeat (dly) @(negedge iclk);
        isyndrome_val = 1'b0;
        idp_delta_val = 1'b1; idp_delta_zero = ~nz[k];
        @(negedge iclk);
        idp_delta_val = 1'b0; idp_delta_zero = 1'b0;
        chk("upd_start", 32'(odp_upd_start), 32'd1);
        chk($sformatf("mode_step%0d", 2 * k + 1), 32'(odp_upd_mode), 32'(modes[2*k +: 2]));
        repeat (dly) @(negedge iclk);
        idp_upd_done = 1'b1;
        @(negedge iclk);
        idp_upd_done = 1'b0;
      end
    end
    repeat (busy_n + 1) begin
      @(negedge iclk);
      chk("no_early_val", 32'(oloc_poly_val), 32'd0);
    end
    iout_busy = 1'b0;
    n = 0;
    while (!oloc_poly_val && n < 50) begin @(negedge iclk); n++; end
    chk("poly_val", 32'(oloc_poly_val), 32'd1);
    chk("latency", 32'(cyc - c0), 32'(exp_lat));
    chk("loc_L", 32'(oloc_L), 32'(exp_l));
    chk("loc_failed", 32'(oloc_failed), 32'(exp_fail));
    chk("rdy_back", 32'(osyndrome_rdy), 32'd1);
    @(negedge iclk);
    chk("poly_pulse", 32'(oloc_poly_val), 32'd0);
    chk("loc_L_hold", 32'(oloc_L), 32'(exp_l));
    chk("n_delta", 32'(n_delta - d0), bypass ? 32'd0 : 32'd8);
    chk("n_upd", 32'(n_upd - u0), bypass ? 32'd0 : 32'd8);
    chk("n_poly", 32'(n_poly - p0), 32'd1);
  endtask

  initial begin
    int d0;
    ireset = 1'b1; isyndrome_val = 1'b0; isyndrome_zero = 1'b0;
    idp_delta_val = 1'b0; idp_delta_zero = 1'b0; idp_upd_done = 1'b0;
    idp_deg = '0; iout_busy = 1'b0;
    repeat (2) @(negedge iclk);
    ireset = 1'b0;
    chk("rst_rdy", 32'(osyndrome_rdy), 32'd1);
    chk("rst_load", 32'(odp_load), 32'd0);
    chk("rst_delta", 32'(odp_delta_start), 32'd0);
    chk("rst_r", 32'(odp_r), 32'd0);
    chk("rst_L", 32'(oloc_L), 32'd0);
    chk("rst_ovf", 32'(ooverflow), 32'd0);

    // One error: SWAP at step 1 then SHIFTs, L=1
    do_run(8'b0000_0001, 16'h0002, 5'd1, 5'd1, 1'b0, 1, 0, -1, 35, 1'b0, 1'b0);
    // Three errors, 3-cycle datapath, 5 stall cycles in OUT
    do_run(8'b0000_0111, 16'h002A, 5'd3, 5'd3, 1'b0, 3, 5, -1, 72, 1'b0, 1'b0);
    chk("ovf_clear", 32'(ooverflow), 32'd0);
    // Beyond t: SWAP,SHIFT,SWAP,UPDATE,SWAP -> L=5, deg 4 fails; stray set at step 7
    do_run(8'b0001_1101, 16'h0262, 5'd5, 5'd4, 1'b1, 1, 0, 3, 35, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(ooverflow), 32'd1);

    // Reset while waiting for the first update
    d0 = n_delta;
    @(negedge iclk);
    isyndrome_val = 1'b1;
    @(negedge iclk);
    isyndrome_val = 1'b0;
    @(negedge iclk);
    chk("rr_delta", 32'(odp_delta_start), 32'd1);
    @(negedge iclk);
    idp_delta_val = 1'b1; idp_delta_zero = 1'b0;
    @(negedge iclk);
    idp_delta_val = 1'b0;
    chk("rr_upd_mode", 32'(odp_upd_mode), 32'd2);
    @(negedge iclk);
    ireset = 1'b1;
    @(negedge iclk);
    ireset = 1'b0;
    chk("rr_rdy", 32'(osyndrome_rdy), 32'd1);
    chk("rr_upd", 32'(odp_upd_start), 32'd0);
    chk("rr_mode", 32'(odp_upd_mode), 32'd0);
    chk("rr_r", 32'(odp_r), 32'd0);
    chk("rr_L", 32'(oloc_L), 32'd0);
    chk("rr_failed", 32'(oloc_failed), 32'd0);
    chk("rr_ovf", 32'(ooverflow), 32'd0);
    idp_upd_done = 1'b1;
    @(negedge iclk);
    idp_upd_done = 1'b0;
    repeat (3) @(negedge iclk);
    chk("rr_no_delta", 32'(n_delta - d0), 32'd1);
    chk("rr_idle", 32'(osyndrome_rdy), 32'd1);

    // All-zero syndromes
`ifdef BCH_BM_CTRL_ZERO_BYPASS_EN
    do_run(8'b0000_0000, 16'h0000, 5'd0, 5'd3, 1'b0, 1, 0, -1, 3, 1'b1, 1'b1);
`else
    do_run(8'b0000_0000, 16'h0000, 5'd0, 5'd0, 1'b0, 1, 0, -1, 35, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
